// File: rtl/led_sequencer.sv
// led_sequencer: four timed LED channels driven from one shared tick prescaler.
// Latency: an accepted write shows on led the next cycle; cfg_ready is low only around reset.
module led_sequencer #(
  parameter int PRESCALE = 4,
  parameter int CNTW     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [1:0]      cfg_ch,
  input  logic [1:0]      cfg_mode,
  input  logic [CNTW-1:0] cfg_t0,
  input  logic [CNTW-1:0] cfg_t1,
  output logic [3:0]      led,
  output logic [3:0]      done,
  output logic            tick
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_ON  = 2'b01;

  typedef enum logic [2:0] {
    IDLE_OFF,
    IDLE_ON,
    PH0,
    PH1,
    HOLD
  } ch_state_t;

  logic [PW-1:0]   pcnt;
  ch_state_t       st  [4];
  logic [CNTW-1:0] cnt [4];
  logic [CNTW-1:0] t0r [4];
  logic [CNTW-1:0] t1r [4];
  logic [3:0]      periodic;

  // Index of the final tick of a phase; a zero length behaves as one tick.
  function automatic logic [CNTW-1:0] last_idx(input logic [CNTW-1:0] t);
    return (t == '0) ? '0 : t - CNTW'(1);
  endfunction

  assign tick = (pcnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt      <= '0;
      cfg_ready <= 1'b0;
      led       <= '0;
      done      <= '0;
      periodic  <= '0;
      for (int i = 0; i < 4; i++) begin
        st[i]  <= IDLE_OFF;
        cnt[i] <= '0;
        t0r[i] <= '0;
        t1r[i] <= '0;
      end
    end else begin
      cfg_ready <= 1'b1;
      pcnt      <= tick ? '0 : pcnt + PW'(1);
      for (int i = 0; i < 4; i++) begin
        // A write wins over a coincident tick; the tick is dropped for this channel.
        if (cfg_valid && cfg_ready && (cfg_ch == 2'(i))) begin
          cnt[i]      <= '0;
          done[i]     <= 1'b0;
          t0r[i]      <= cfg_t0;
          t1r[i]      <= cfg_t1;
          periodic[i] <= cfg_mode[0];
          case (cfg_mode)
            MODE_OFF: begin st[i] <= IDLE_OFF; led[i] <= 1'b0; end
            MODE_ON:  begin st[i] <= IDLE_ON;  led[i] <= 1'b1; end
            default:  begin st[i] <= PH0;      led[i] <= 1'b0; end
          endcase
        end else if (tick) begin
          case (st[i])
            PH0: begin
              if (cnt[i] == last_idx(t0r[i])) begin
                st[i]  <= PH1;
                cnt[i] <= '0;
                led[i] <= 1'b1;
              end else begin
                cnt[i] <= cnt[i] + CNTW'(1);
              end
            end
            PH1: begin
              if (cnt[i] == last_idx(t1r[i])) begin
                cnt[i] <= '0;
                led[i] <= 1'b0;
                if (periodic[i]) begin
                  st[i] <= PH0;
                end else begin
                  st[i]   <= HOLD;
                  done[i] <= 1'b1;
                end
              end else begin
                cnt[i] <= cnt[i] + CNTW'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
